sram_rsp_32x128: RTL and testbench

SRAM_RSP_32X128 -- requirements
Module: sram_rsp_32x128

---
 rtl/sram_rsp_pkg.sv | 26 ++
 rtl/sram_rsp_fifo.sv | 79 +++++++
 rtl/sram_rsp_32x128.sv | 106 ++++++++++
 tb/tb_sram_rsp_32x128.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_rsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_rsp_pkg
// Description : Shared defaults and request type for the byte-maskable SRAM
//               with buffered read responses.
// Contents    : DEF_DATA_WIDTH, DEF_ADDR_WIDTH, DEF_RAM_DEPTH, DEF_RSP_DEPTH,
//               req_t (we, addr, wdata, wmask)
// Revision    : 1.0 - initial release
// ============================================================================
package sram_rsp_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 7;
    localparam int DEF_RAM_DEPTH  = 1 << DEF_ADDR_WIDTH;
    localparam int DEF_RSP_DEPTH  = 2;

    // One request as presented on the request port (default geometry).
    typedef struct packed {
        logic                          we;
        logic [DEF_ADDR_WIDTH-1:0]     addr;
        logic [DEF_DATA_WIDTH-1:0]     wdata;
        logic [DEF_DATA_WIDTH/8-1:0]   wmask;
    } req_t;

endpackage : sram_rsp_pkg
`default_nettype wire

// File: rtl/sram_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sram_rsp_fifo
// Description : Small in-order FIFO holding read responses. Output word is
//               presented directly from storage (first-word fall-through).
// Ports       : clk, rst_n      - clock, async active-low reset
//               i_push/i_data   - enqueue a word
//               i_pop           - dequeue head word (ignored when empty)
//               o_valid/o_data  - head word present / head word (0 if empty)
//               o_count         - current occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module sram_rsp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  wire logic                             clk,
    input  wire logic                             rst_n,
    input  wire logic                             i_push,
    input  wire logic [WIDTH-1:0]                 i_data,
    input  wire logic                             i_pop,
    output logic                                  o_valid,
    output logic [WIDTH-1:0]                      o_data,
    output logic [$clog2(DEPTH+1)-1:0]            o_count
);

    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_not_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_not_empty = (r_count != '0);
    assign w_do_pop    = i_pop && w_not_empty;
    // A push into a full buffer is only legal when the head leaves the same edge.
    assign w_do_push   = i_push && ((r_count != c_full) || w_do_pop);

    // Pointers wrap explicitly so non-power-of-two depths stay in range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= (r_wptr == c_ptr_last) ? '0 : r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= (r_rptr == c_ptr_last) ? '0 : r_rptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; emptiness is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    assign o_valid = w_not_empty;
    assign o_data  = w_not_empty ? r_mem[r_rptr] : '0;
    assign o_count = r_count;

endmodule : sram_rsp_fifo
`default_nettype wire

// File: rtl/sram_rsp_32x128.sv
`default_nettype none
// ============================================================================
// Module      : sram_rsp_32x128
// Description : Single-port byte-maskable SRAM with valid/ready request port
//               and a buffered, in-order read-response port.
// Ports       : clk0, rst0_n                 - clock, async active-low reset
//               req_valid/req_ready           - request handshake
//               req_we/req_addr/req_wdata/req_wmask - request payload
//               rsp_valid/rsp_ready/rsp_rdata - read response handshake
//               acc_cnt                       - saturating accepted-request count
// Revision    : 1.0 - initial release
// ============================================================================
module sram_rsp_32x128
    import sram_rsp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
    input  wire logic                      clk0,
    input  wire logic                      rst0_n,
    input  wire logic                      req_valid,
    output logic                           req_ready,
    input  wire logic                      req_we,
    input  wire logic [ADDR_WIDTH-1:0]     req_addr,
    input  wire logic [DATA_WIDTH-1:0]     req_wdata,
    input  wire logic [DATA_WIDTH/8-1:0]   req_wmask,
    output logic                           rsp_valid,
    input  wire logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic [15:0]                    acc_cnt
);

    localparam int c_bytes = DATA_WIDTH / 8;
    localparam int c_cnt_w = $clog2(RSP_DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_rsp_full = c_cnt_w'(RSP_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic                  r_req_ready;
    logic [15:0]           r_acc_cnt;

    logic                  w_accept;
    logic                  w_addr_ok;
    logic                  w_wr;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [c_cnt_w-1:0]    w_count;
    logic [c_cnt_w-1:0]    w_count_next;

    assign w_accept  = req_valid && r_req_ready;
    assign w_addr_ok = (32'(req_addr) < 32'(RAM_DEPTH));
    assign w_wr      = w_accept && req_we && w_addr_ok;
    assign w_push    = w_accept && !req_we;
    assign w_pop     = rsp_valid && rsp_ready;
    // Out-of-range reads return zero rather than aliasing into the array.
    assign w_rd_data = w_addr_ok ? r_mem[req_addr] : '0;

    // Byte-lane write; memory keeps its contents across reset.
    always_ff @(posedge clk0) begin
        if (w_wr) begin
            for (int b = 0; b < c_bytes; b++) begin
                if (req_wmask[b]) begin
                    r_mem[req_addr][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
    end

    sram_rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk0),
        .rst_n   (rst0_n),
        .i_push  (w_push),
        .i_data  (w_rd_data),
        .i_pop   (w_pop),
        .o_valid (rsp_valid),
        .o_data  (rsp_rdata),
        .o_count (w_count)
    );

    // Ready is computed from the occupancy the buffer will have after this
    // edge and registered, so rsp_ready never reaches req_ready combinationally.
    // Reset holds it low; it rises on the first edge after reset release.
    assign w_count_next = w_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            r_req_ready <= 1'b0;
            r_acc_cnt   <= '0;
        end else begin
            r_req_ready <= (w_count_next < c_rsp_full);
            if (w_accept && (r_acc_cnt != 16'hFFFF)) begin
                r_acc_cnt <= r_acc_cnt + 16'd1;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign acc_cnt   = r_acc_cnt;

endmodule : sram_rsp_32x128
`default_nettype wire

// File: tb/tb_sram_rsp_32x128.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_rsp_32x128
// Description : Self-checking bench for sram_rsp_32x128. Read expectations are
//               queued on acceptance and compared when responses are popped.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_rsp_32x128;
    import sram_rsp_pkg::*;

    logic        clk0;
    logic        rst0_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [15:0] acc_cnt;

    int          n_pass;
    int          n_total;
    int          exp_acc;
    logic [31:0] exp_q [$];
    logic [31:0] model_mem [128];

    sram_rsp_32x128 dut (
        .clk0      (clk0),
        .rst0_n    (rst0_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .acc_cnt   (acc_cnt)
    );

    initial begin
        clk0 = 1'b0;
        forever #5 clk0 = ~clk0;
    end

    // Compares every popped response against the head of the expected queue.
    task automatic run_monitor();
        logic [31:0] e;
        forever begin
            @(negedge clk0);
            if (rst0_n && rsp_valid && rsp_ready) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rsp_unexpected: got %h, none expected", rsp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_rdata !== e) $display("FAIL rsp_data: got %h expected %h", rsp_rdata, e);
                    else n_pass++;
                end
            end
        end
    endtask

    // Presents one request and returns 1 time unit after the accepting edge.
    task automatic do_req(input logic we, input logic [6:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask);
        int waits;
        waits     = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        @(negedge clk0);
        while (!req_ready && waits < 200) begin
            waits++;
            @(negedge clk0);
        end
        if (!req_ready) begin
            n_total++;
            $display("FAIL req_accept_timeout: req_ready got %b expected 1", req_ready);
        end else begin
            exp_acc++;
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (wmask[b]) model_mem[addr][b*8 +: 8] = wdata[b*8 +: 8];
            end else begin
                exp_q.push_back(model_mem[addr]);
            end
        end
        @(posedge clk0);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 50) begin
            @(posedge clk0);
            #1;
            n++;
        end
        n_total++;
        if (exp_q.size() != 0) $display("FAIL drain: pending got %0d expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rst0_n = 1'b1;
        #2 rst0_n = 1'b0;
        exp_acc = 0;
        #1;
        n_total++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b expected 0", req_ready); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); else n_pass++;
        n_total++; if (rsp_rdata !== 32'h0) $display("FAIL rst_rsp_rdata: got %h expected 0", rsp_rdata); else n_pass++;
        n_total++; if (acc_cnt !== 16'h0) $display("FAIL rst_acc_cnt: got %h expected 0", acc_cnt); else n_pass++;
        repeat (3) @(posedge clk0);
        #1 rst0_n = 1'b1;
        #1;
        n_total++; if (req_ready !== 1'b0) $display("FAIL rst_release_ready_early: got %b expected 0", req_ready); else n_pass++;
        @(posedge clk0);
        #1;
        n_total++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready: got %b expected 1", req_ready); else n_pass++;
    endtask

    task automatic test_write_read();
        do_req(1'b1, 7'd10, 32'hFACECAFE, 4'hF);
        do_req(1'b0, 7'd10, 32'h0, 4'h0);
        n_total++; if (rsp_valid !== 1'b1) $display("FAIL wr_rd_valid: got %b expected 1", rsp_valid); else n_pass++;
        n_total++; if (rsp_rdata !== 32'hFACECAFE) $display("FAIL wr_rd_data: got %h expected facecafe", rsp_rdata); else n_pass++;
        n_total++; if (acc_cnt !== 16'd2) $display("FAIL wr_rd_acc: got %0d expected 2", acc_cnt); else n_pass++;
        drain();
    endtask

    task automatic test_byte_mask();
        do_req(1'b1, 7'd5, 32'h11223344, 4'hF);
        do_req(1'b1, 7'd5, 32'hAABBCCDD, 4'b0101);
        do_req(1'b0, 7'd5, 32'h0, 4'h0);
        n_total++; if (rsp_rdata !== 32'h11BB33DD) $display("FAIL byte_mask: got %h expected 11bb33dd", rsp_rdata); else n_pass++;
        drain();
    endtask

    task automatic test_zero_mask();
        do_req(1'b1, 7'd5, 32'hFFFFFFFF, 4'h0);
        do_req(1'b0, 7'd5, 32'h0, 4'h0);
        n_total++; if (rsp_rdata !== 32'h11BB33DD) $display("FAIL zero_mask_data: got %h expected 11bb33dd", rsp_rdata); else n_pass++;
        n_total++; if (acc_cnt !== 16'(exp_acc)) $display("FAIL zero_mask_acc: got %0d expected %0d", acc_cnt, exp_acc); else n_pass++;
        drain();
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 3; a++) do_req(1'b1, 7'(a), 32'(a), 4'hF);
        rsp_ready = 1'b0;
        do_req(1'b0, 7'd0, 32'h0, 4'h0);
        do_req(1'b0, 7'd1, 32'h0, 4'h0);
        n_total++; if (req_ready !== 1'b0) $display("FAIL bp_ready_low: got %b expected 0", req_ready); else n_pass++;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 7'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk0);
            n_total++; if (req_ready !== 1'b0) $display("FAIL bp_third_wait: got %b expected 0", req_ready); else n_pass++;
            n_total++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid_hold: got %b expected 1", rsp_valid); else n_pass++;
            n_total++; if (rsp_rdata !== 32'h0) $display("FAIL bp_data_hold: got %h expected 0", rsp_rdata); else n_pass++;
        end
        n_total++; if (acc_cnt !== 16'(exp_acc)) $display("FAIL bp_acc: got %0d expected %0d", acc_cnt, exp_acc); else n_pass++;
        @(posedge clk0);
        #1 rsp_ready = 1'b1;
        do_req(1'b0, 7'd2, 32'h0, 4'h0);
        drain();
    endtask

    task automatic test_push_pop();
        req_t tbl [5];
        tbl[0] = '{we: 1'b0, addr: 7'd0,  wdata: 32'h0, wmask: 4'h0};
        tbl[1] = '{we: 1'b0, addr: 7'd10, wdata: 32'h0, wmask: 4'h0};
        tbl[2] = '{we: 1'b0, addr: 7'd1,  wdata: 32'h0, wmask: 4'h0};
        tbl[3] = '{we: 1'b0, addr: 7'd5,  wdata: 32'h0, wmask: 4'h0};
        tbl[4] = '{we: 1'b0, addr: 7'd2,  wdata: 32'h0, wmask: 4'h0};
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].wmask);
            n_total++; if (rsp_valid !== 1'b1) $display("FAIL pp_valid: got %b expected 1", rsp_valid); else n_pass++;
            n_total++; if (req_ready !== 1'b1) $display("FAIL pp_ready: got %b expected 1", req_ready); else n_pass++;
        end
        drain();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        do_req(1'b0, 7'd0, 32'h0, 4'h0);
        do_req(1'b0, 7'd1, 32'h0, 4'h0);
        rst0_n = 1'b0;
        #1;
        exp_q.delete();
        exp_acc = 0;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b expected 0", rsp_valid); else n_pass++;
        n_total++; if (acc_cnt !== 16'h0) $display("FAIL mid_rst_acc: got %h expected 0", acc_cnt); else n_pass++;
        n_total++; if (req_ready !== 1'b0) $display("FAIL mid_rst_ready: got %b expected 0", req_ready); else n_pass++;
        repeat (2) @(posedge clk0);
        #1 rst0_n = 1'b1;
        @(posedge clk0);
        #1 rsp_ready = 1'b1;
        do_req(1'b0, 7'd10, 32'h0, 4'h0);
        n_total++; if (rsp_rdata !== 32'hFACECAFE) $display("FAIL mid_rst_mem: got %h expected facecafe", rsp_rdata); else n_pass++;
        n_total++; if (acc_cnt !== 16'd1) $display("FAIL mid_rst_acc_after: got %0d expected 1", acc_cnt); else n_pass++;
        drain();
    endtask

    task automatic test_saturation();
        rst0_n = 1'b0;
        @(posedge clk0);
        #1 rst0_n = 1'b1;
        @(posedge clk0);
        #1;
        n_total++; if (req_ready !== 1'b1) $display("FAIL sat_ready: got %b expected 1", req_ready); else n_pass++;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 7'd0;
        req_wdata = 32'hDEADBEEF; req_wmask = 4'h0;
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk0);
            #1;
            if (i == 65533) begin
                n_total++; if (acc_cnt !== 16'hFFFE) $display("FAIL sat_pre: got %h expected fffe", acc_cnt); else n_pass++;
            end
            if (i == 65534) begin
                n_total++; if (acc_cnt !== 16'hFFFF) $display("FAIL sat_hit: got %h expected ffff", acc_cnt); else n_pass++;
            end
        end
        req_valid = 1'b0;
        n_total++; if (acc_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %h expected ffff", acc_cnt); else n_pass++;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        exp_acc   = 0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        rsp_ready = 1'b1;
        fork
            run_monitor();
        join_none
        test_reset();
        test_write_read();
        test_byte_mask();
        test_zero_mask();
        test_back_to_back();
        test_push_pop();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_sram_rsp_32x128
`default_nettype wire
